// File: rtl/edge_kernel_pkg.sv
// Shared definitions for the edge_kernel gradient engine.
// Holds the kernel-select encoding, the per-kernel coefficient constants,
// the pipeline depth and the guard width used to size Gx/Gy.
// No ports (package).
package edge_kernel_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_SCHARR  = 2'd2
    } mode_e;

    // Coefficients as (edge, middle, edge) along the differentiated axis.
    localparam logic [3:0] SOBEL_EDGE   = 4'd1;
    localparam logic [3:0] SOBEL_MID    = 4'd2;
    localparam logic [3:0] PREWITT_EDGE = 4'd1;
    localparam logic [3:0] PREWITT_MID  = 4'd1;
    localparam logic [3:0] SCHARR_EDGE  = 4'd3;
    localparam logic [3:0] SCHARR_MID   = 4'd10;

    // Cycles from the accepting we_i cycle to valid_o.
    localparam int PIPE_LAT = 3;

    // Extra bits on top of DATA_W so Scharr's 16*(2^DATA_W-1) fits signed.
    localparam int GRAD_GUARD_W = 6;

    // Raw mode select to kernel; the unused code 3 falls back to Sobel.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_PREWITT;
            2'd2:    m = MODE_SCHARR;
            default: m = MODE_SOBEL;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] coef_edge(input mode_e m);
        logic [3:0] k;
        case (m)
            MODE_PREWITT: k = PREWITT_EDGE;
            MODE_SCHARR:  k = SCHARR_EDGE;
            default:      k = SOBEL_EDGE;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] coef_mid(input mode_e m);
        logic [3:0] k;
        case (m)
            MODE_PREWITT: k = PREWITT_MID;
            MODE_SCHARR:  k = SCHARR_MID;
            default:      k = SOBEL_MID;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/edge_kernel_line_buffer.sv
// line_buffer: single-clock circular buffer giving a fixed COLS-strobe delay.
// Each we_i strobe reads the oldest entry and overwrites it with data_i, so
// data_o shows the pixel accepted COLS strobes earlier (one image row above).
// Ports: clk, rst (async active-low), we_i (strobe), data_i (pixel in),
//        data_o (pixel delayed by one row, valid while we_i is high).
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int COLS   = 360
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(COLS - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     ptr_r;

    // Oldest entry is read before the same slot is overwritten.
    assign data_o = mem_r[ptr_r];

    // Pointer walks 0..COLS-1 so the delay is exactly one row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {AW{1'b0}};
        end else if (we_i) begin
            if (ptr_r == PTR_LAST) begin
                ptr_r <= {AW{1'b0}};
            end else begin
                ptr_r <= ptr_r + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because border windows are never emitted.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_r[ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/edge_kernel.sv
// edge_kernel: streaming 3x3 gradient engine (Sobel / Prewitt / Scharr).
// Pixels arrive in raster order on we_i; two chained line buffers feed a 3x3
// window, then Gx/Gy and |Gx|+|Gy| with saturation to DATA_W bits. Only
// windows with an interior centre produce output, PIPE_LAT cycles after the
// pixel that completes them.
// Ports: clk, rst (async active-low), data_i/we_i (pixel stream),
//        mode_i (kernel select, latched at pixel (0,0)),
//        thresh_i (only with EDGE_KERNEL_THRESH_EN, latched with mode_i),
//        data_o/valid_o (gradient result), done_o (last result of a frame).
// Build option: define EDGE_KERNEL_THRESH_EN to binarise the output against
// thresh_i (all ones when magnitude >= thresh_i, else zero).
module edge_kernel
    import edge_kernel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ROWS   = 480,
    parameter int COLS   = 360,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    input  logic [1:0]        mode_i,
`ifdef EDGE_KERNEL_THRESH_EN
    input  logic [DATA_W-1:0] thresh_i,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              done_o
);
    localparam int GRAD_W = DATA_W + GRAD_GUARD_W;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_TAG  = CW'(2);
    localparam logic [RW-1:0]     ROW_TAG  = RW'(2);
    localparam logic [GRAD_W-1:0] SAT_MAX  = {{GRAD_GUARD_W{1'b0}}, {DATA_W{1'b1}}};

    logic [CW-1:0]            col_cnt_r;
    logic [RW-1:0]            row_cnt_r;
    logic                     frame_start_s;
    logic                     frame_last_s;
    logic                     interior_s;
    mode_e                    mode_lat_r;
    mode_e                    mode_eff_s;
    mode_e                    m1_r;
    logic [DATA_W-1:0]        lb1_out_s;
    logic [DATA_W-1:0]        lb2_out_s;
    logic [DATA_W-1:0]        win_r [3][3];
    logic [PIPE_LAT-1:0]      vld_pipe_r;
    logic [PIPE_LAT-1:0]      done_pipe_r;
    logic signed [GRAD_W-1:0] ce_s;
    logic signed [GRAD_W-1:0] cm_s;
    logic signed [GRAD_W-1:0] gx_s;
    logic signed [GRAD_W-1:0] gy_s;
    logic signed [GRAD_W-1:0] gx_r;
    logic signed [GRAD_W-1:0] gy_r;
    logic [GRAD_W-1:0]        abs_x_s;
    logic [GRAD_W-1:0]        abs_y_s;
    logic [GRAD_W-1:0]        mag_s;
    logic [DATA_W-1:0]        sat_s;
    logic [DATA_W-1:0]        out_s;
    logic [DATA_W-1:0]        data_o_r;
`ifdef EDGE_KERNEL_THRESH_EN
    logic [DATA_W-1:0]        th_lat_r;
    logic [DATA_W-1:0]        th_eff_s;
    logic [DATA_W-1:0]        th1_r;
    logic [DATA_W-1:0]        th2_r;
`endif

    function automatic logic signed [GRAD_W-1:0] widen(input logic [DATA_W-1:0] p);
        return $signed({{GRAD_GUARD_W{1'b0}}, p});
    endfunction

    assign frame_start_s = (row_cnt_r == {RW{1'b0}}) && (col_cnt_r == {CW{1'b0}});
    assign frame_last_s  = (row_cnt_r == ROW_LAST) && (col_cnt_r == COL_LAST);
    // Pixel (r+1,c+1) completes the window centred at (r,c); interior centres need r,c >= 1.
    assign interior_s    = (row_cnt_r >= ROW_TAG) && (col_cnt_r >= COL_TAG);

    line_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .COLS(COLS)) u_lb1 (
        .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),    .data_o(lb1_out_s)
    );
    line_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .COLS(COLS)) u_lb2 (
        .clk(clk), .rst(rst), .we_i(we_i), .data_i(lb1_out_s), .data_o(lb2_out_s)
    );

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_r <= {CW{1'b0}};
            row_cnt_r <= {RW{1'b0}};
        end else if (we_i) begin
            if (col_cnt_r == COL_LAST) begin
                col_cnt_r <= {CW{1'b0}};
                if (row_cnt_r == ROW_LAST) begin
                    row_cnt_r <= {RW{1'b0}};
                end else begin
                    row_cnt_r <= row_cnt_r + 1'b1;
                end
            end else begin
                col_cnt_r <= col_cnt_r + 1'b1;
            end
        end
    end

    // Frame-wide settings: fresh inputs on pixel (0,0), latched copy otherwise.
    always_comb begin
        if (frame_start_s) begin
            mode_eff_s = decode_mode(mode_i);
        end else begin
            mode_eff_s = mode_lat_r;
        end
`ifdef EDGE_KERNEL_THRESH_EN
        if (frame_start_s) begin
            th_eff_s = thresh_i;
        end else begin
            th_eff_s = th_lat_r;
        end
`endif
    end

    // Frame settings latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_lat_r <= MODE_SOBEL;
`ifdef EDGE_KERNEL_THRESH_EN
            th_lat_r   <= {DATA_W{1'b0}};
`endif
        end else if (we_i) begin
            mode_lat_r <= mode_eff_s;
`ifdef EDGE_KERNEL_THRESH_EN
            th_lat_r   <= th_eff_s;
`endif
        end
    end

    // Stage 1: window shift on each accepted pixel; settings travel with the
    // window so a new frame cannot alter results still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= {DATA_W{1'b0}};
                end
            end
            m1_r <= MODE_SOBEL;
`ifdef EDGE_KERNEL_THRESH_EN
            th1_r <= {DATA_W{1'b0}};
`endif
        end else if (we_i) begin
            for (int i = 0; i < 3; i++) begin
                win_r[i][0] <= win_r[i][1];
                win_r[i][1] <= win_r[i][2];
            end
            win_r[0][2] <= lb2_out_s;
            win_r[1][2] <= lb1_out_s;
            win_r[2][2] <= data_i;
            m1_r        <= mode_eff_s;
`ifdef EDGE_KERNEL_THRESH_EN
            th1_r       <= th_eff_s;
`endif
        end
    end

    // Valid/done tags run freely so gaps in we_i never stall results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_r  <= {PIPE_LAT{1'b0}};
            done_pipe_r <= {PIPE_LAT{1'b0}};
        end else begin
            vld_pipe_r  <= {vld_pipe_r[PIPE_LAT-2:0], we_i && interior_s};
            done_pipe_r <= {done_pipe_r[PIPE_LAT-2:0], we_i && frame_last_s};
        end
    end

    // Stage 2 math: Gx = right column minus left, Gy = bottom row minus top.
    always_comb begin
        ce_s = $signed({{(GRAD_W-4){1'b0}}, coef_edge(m1_r)});
        cm_s = $signed({{(GRAD_W-4){1'b0}}, coef_mid(m1_r)});
        gx_s = ce_s * (widen(win_r[0][2]) - widen(win_r[0][0]))
             + cm_s * (widen(win_r[1][2]) - widen(win_r[1][0]))
             + ce_s * (widen(win_r[2][2]) - widen(win_r[2][0]));
        gy_s = ce_s * (widen(win_r[2][0]) - widen(win_r[0][0]))
             + cm_s * (widen(win_r[2][1]) - widen(win_r[0][1]))
             + ce_s * (widen(win_r[2][2]) - widen(win_r[0][2]));
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx_r <= {GRAD_W{1'b0}};
            gy_r <= {GRAD_W{1'b0}};
`ifdef EDGE_KERNEL_THRESH_EN
            th2_r <= {DATA_W{1'b0}};
`endif
        end else begin
            gx_r <= gx_s;
            gy_r <= gy_s;
`ifdef EDGE_KERNEL_THRESH_EN
            th2_r <= th1_r;
`endif
        end
    end

    // Stage 3 math: |Gx|+|Gy|, clip to DATA_W, optional threshold.
    always_comb begin
        if (gx_r[GRAD_W-1]) begin
            abs_x_s = -gx_r;
        end else begin
            abs_x_s = gx_r;
        end
        if (gy_r[GRAD_W-1]) begin
            abs_y_s = -gy_r;
        end else begin
            abs_y_s = gy_r;
        end
        mag_s = abs_x_s + abs_y_s;
        if (mag_s > SAT_MAX) begin
            sat_s = {DATA_W{1'b1}};
        end else begin
            sat_s = mag_s[DATA_W-1:0];
        end
`ifdef EDGE_KERNEL_THRESH_EN
        if (sat_s >= th2_r) begin
            out_s = {DATA_W{1'b1}};
        end else begin
            out_s = {DATA_W{1'b0}};
        end
`else
        out_s = sat_s;
`endif
    end

    // Stage 3 output register; data_o holds between valid results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o_r <= {DATA_W{1'b0}};
        end else if (vld_pipe_r[PIPE_LAT-2]) begin
            data_o_r <= out_s;
        end
    end

    assign data_o  = data_o_r;
    assign valid_o = vld_pipe_r[PIPE_LAT-1];
    assign done_o  = done_pipe_r[PIPE_LAT-1];

endmodule

// File: tb/tb_edge_kernel.sv
// Self-checking bench for edge_kernel on a 4x5 image. Expected results come
// from a reference gradient computed on the bench's own copy of the image and
// are queued when the completing pixel is driven; a monitor pops and checks
// value, latency, done flag and hold behaviour.
module tb_edge_kernel;
    import edge_kernel_pkg::*;

    localparam int DW = 8;
    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          done;
        int            due;
        int            r;
        int            c;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          we_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] thresh;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          done_o;

    int   total;
    int   bad;
    int   cyc;
    int   pr;
    int   pc;
    int   n_out;
    int   n_done;
    int   img [ROWS][COLS];
    logic [1:0] frame_mode;
    int   frame_th;
    logic [DW-1:0] last_data;
    exp_t exp_q [$];

    edge_kernel #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .we_i(we_i), .mode_i(mode_i),
`ifdef EDGE_KERNEL_THRESH_EN
        .thresh_i(thresh),
`endif
        .data_o(data_o), .valid_o(valid_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result for the window centred at (r,c) of the current frame.
    function automatic int model_px(input int r, input int c);
        int a, b, gx, gy, mag;
        case (frame_mode)
            2'd1:    begin a = 1; b = 1;  end
            2'd2:    begin a = 3; b = 10; end
            default: begin a = 1; b = 2;  end
        endcase
        gx = a * (img[r-1][c+1] - img[r-1][c-1]) + b * (img[r][c+1] - img[r][c-1])
           + a * (img[r+1][c+1] - img[r+1][c-1]);
        gy = a * (img[r+1][c-1] - img[r-1][c-1]) + b * (img[r+1][c] - img[r-1][c])
           + a * (img[r+1][c+1] - img[r-1][c+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (mag > 255) mag = 255;
`ifdef EDGE_KERNEL_THRESH_EN
        if (mag >= frame_th) mag = 255;
        else mag = 0;
`endif
        return mag;
    endfunction

    task automatic send_pixel(input int p, input logic [1:0] m, input int gap);
        exp_t e;
        data_i = p[DW-1:0];
        mode_i = m;
        we_i   = 1'b1;
        if (pr == 0 && pc == 0) begin
            frame_mode = m;
            frame_th   = int'(thresh);
        end
        img[pr][pc] = p;
        if (pr >= 2 && pc >= 2) begin
            e.data = model_px(pr - 1, pc - 1);
            e.done = (pr == ROWS - 1) && (pc == COLS - 1);
            e.due  = cyc + PIPE_LAT;
            e.r    = pr - 1;
            e.c    = pc - 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        we_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        if (pc == COLS - 1) begin
            pc = 0;
            pr = (pr == ROWS - 1) ? 0 : pr + 1;
        end else begin
            pc = pc + 1;
        end
    endtask

    // kind 0: flat, 1: vertical step (cols 0-1 = 0, rest = hi), 2: random.
    task automatic send_frame(input int kind, input int hi, input logic [1:0] m0,
                              input logic [1:0] m_rest, input int gap);
        int p;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    0:       p = hi;
                    1:       p = (c >= 2) ? hi : 0;
                    default: p = int'($urandom_range(0, 255));
                endcase
                send_pixel(p, (r == 0 && c == 0) ? m0 : m_rest, gap);
            end
        end
    endtask

    task automatic drain(input int want_out, input int want_done, input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (4) begin @(posedge clk); #1; end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL %s_drain observed=%0d pending expected=0", tag, exp_q.size());
        end
        total++;
        assert (n_out == want_out) else begin
            bad++; $error("FAIL %s_count observed=%0d expected=%0d", tag, n_out, want_out);
        end
        total++;
        assert (n_done == want_done) else begin
            bad++; $error("FAIL %s_done_count observed=%0d expected=%0d", tag, n_done, want_done);
        end
        n_out  = 0;
        n_done = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        assert (valid_o === 1'b0) else begin
            bad++; $error("FAIL %s_valid observed=%0b expected=0", tag, valid_o);
        end
        total++;
        assert (done_o === 1'b0) else begin
            bad++; $error("FAIL %s_done observed=%0b expected=0", tag, done_o);
        end
        total++;
        assert (data_o === {DW{1'b0}}) else begin
            bad++; $error("FAIL %s_data observed=%0d expected=0", tag, data_o);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid_o.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            last_data = {DW{1'b0}};
        end else if (valid_o) begin
            n_out++;
            if (done_o) n_done++;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++; $error("FAIL unexpected_valid observed=1 expected=0 cyc=%0d", cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                assert (data_o === e.data) else begin
                    bad++; $error("FAIL data_r%0d_c%0d observed=%0d expected=%0d", e.r, e.c, data_o, e.data);
                end
                total++;
                assert (cyc == e.due) else begin
                    bad++; $error("FAIL latency_r%0d_c%0d observed=%0d expected=%0d", e.r, e.c, cyc, e.due);
                end
                total++;
                assert (done_o === e.done) else begin
                    bad++; $error("FAIL done_r%0d_c%0d observed=%0b expected=%0b", e.r, e.c, done_o, e.done);
                end
            end
            last_data = data_o;
        end else begin
            total++;
            assert (done_o === 1'b0) else begin
                bad++; $error("FAIL stray_done observed=%0b expected=0 cyc=%0d", done_o, cyc);
            end
            total++;
            assert (data_o === last_data) else begin
                bad++; $error("FAIL data_hold observed=%0d expected=%0d cyc=%0d", data_o, last_data, cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst = 1'b0; we_i = 1'b0; data_i = '0; mode_i = 2'd0; thresh = '0;
        total = 0; bad = 0; cyc = 0; pr = 0; pc = 0; n_out = 0; n_done = 0;
        frame_mode = 2'd0; frame_th = 0; last_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Flat image, Sobel: six zero results.
        send_frame(0, 100, 2'd0, 2'd0, 0);
        drain(6, 1, "flat");

        // Step 0/10 with every kernel back to back (mode 3 behaves as Sobel).
        send_frame(1, 10, 2'd0, 2'd0, 0);
        send_frame(1, 10, 2'd1, 2'd1, 0);
        send_frame(1, 10, 2'd2, 2'd2, 0);
        send_frame(1, 10, 2'd3, 2'd3, 0);
        drain(24, 4, "step_modes");

        // Saturation: 0/255 step with Scharr clips 4080 to 255.
        send_frame(1, 255, 2'd2, 2'd2, 0);
        drain(6, 1, "saturate");

        // Gaps of two idle cycles between pixels.
        send_frame(1, 10, 2'd0, 2'd0, 2);
        drain(6, 1, "gaps");

        // Mid-frame mode change must be ignored.
        send_frame(1, 10, 2'd0, 2'd2, 0);
        drain(6, 1, "mode_hold");

        // Random images under each kernel.
        send_frame(2, 0, 2'd0, 2'd1, 0);
        send_frame(2, 0, 2'd1, 2'd2, 1);
        send_frame(2, 0, 2'd2, 2'd0, 0);
        drain(18, 3, "random");

        // Reset after 12 pixels, then a full frame.
        for (int i = 0; i < 12; i++) send_pixel((i % COLS >= 2) ? 10 : 0, 2'd0, 0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b1; pr = 0; pc = 0; n_out = 0; n_done = 0;
        send_frame(1, 10, 2'd0, 2'd0, 0);
        drain(6, 1, "after_reset");

        // Reset while a result is in flight: it must be discarded.
        for (int i = 0; i < 13; i++) send_pixel((i % COLS >= 2) ? 10 : 0, 2'd2, 0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; pr = 0; pc = 0; n_out = 0; n_done = 0;
        repeat (5) begin @(posedge clk); #1; end
        send_frame(1, 10, 2'd0, 2'd0, 0);
        drain(6, 1, "inflight_reset");

`ifdef EDGE_KERNEL_THRESH_EN
        thresh = 8'd35;
        send_frame(1, 10, 2'd0, 2'd0, 0);
        drain(6, 1, "thresh35");
        thresh = 8'd41;
        send_frame(1, 10, 2'd0, 2'd0, 0);
        drain(6, 1, "thresh41");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
